// File: rtl/fc_stream_host.sv
// Host-side streaming driver for a fully connected layer: transmits an N-word input
// vector, collects M result words and reports status plus the elapsed RUN cycles.
module fc_stream_host #(
   parameter int M = 8,
   parameter int N = 6,
   parameter int T = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 load_en,
   input  logic [$clog2(N)-1:0] load_addr,
   input  logic signed [T-1:0]  load_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic signed [T-1:0]  tx_data,
   input  logic                 rx_valid,
   output logic                 rx_ready,
   input  logic signed [T-1:0]  rx_data,
   input  logic [$clog2(M)-1:0] res_addr,
   output logic signed [T-1:0]  res_data,
   output logic                 busy,
   output logic                 done,
   output logic [31:0]          cycle_count
);
   localparam int XW = $clog2(N);
   localparam int YW = $clog2(M);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [XW:0]   N_END   = (XW+1)'(N);
   localparam logic [YW:0]   M_END   = (YW+1)'(M);
   localparam logic [XW-1:0] TX_LAST = XW'(N-1);

   logic [1:0]          state;
   logic [XW-1:0]       tx_idx;
   logic [YW:0]         rx_idx;
   logic                tx_complete;
   logic signed [T-1:0] xbuf [N];
   logic signed [T-1:0] ybuf [M];
   logic                run;
   logic                tx_fire;
   logic                rx_fire;

   // Handshake outputs derive only from registered state, so they cannot retract mid-stall.
   always_comb begin
      run      = (state == S_RUN);
      busy     = run;
      done     = (state == S_DONE);
      tx_valid = run && !tx_complete;
      tx_data  = tx_valid ? xbuf[tx_idx] : '0;
      rx_ready = run && (rx_idx < M_END);
      tx_fire  = tx_valid && tx_ready;
      rx_fire  = rx_ready && rx_valid;
      res_data = ({1'b0, res_addr} < M_END) ? ybuf[res_addr] : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         tx_idx      <= '0;
         rx_idx      <= '0;
         tx_complete <= 1'b0;
         cycle_count <= '0;
         for (int i = 0; i < N; i++) xbuf[i] <= '0;
         for (int i = 0; i < M; i++) ybuf[i] <= '0;
      end else begin
         case (state)
            S_RUN: begin
               if (tx_fire) begin
                  if (tx_idx == TX_LAST) tx_complete <= 1'b1;
                  else                   tx_idx      <= tx_idx + XW'(1);
               end
               if (rx_fire) begin
                  ybuf[rx_idx[YW-1:0]] <= rx_data;
                  rx_idx               <= rx_idx + (YW+1)'(1);
               end
               if (cycle_count != '1) cycle_count <= cycle_count + 32'd1;
               // Exit one cycle after both directions are finished, in whichever order.
               if (tx_complete && (rx_idx == M_END)) state <= S_DONE;
            end
            default: begin
               if (load_en && ({1'b0, load_addr} < N_END)) xbuf[load_addr] <= load_data;
               if (start) begin
                  state       <= S_RUN;
                  tx_idx      <= '0;
                  rx_idx      <= '0;
                  tx_complete <= 1'b0;
                  cycle_count <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fc_stream_host.sv
// Bench for fc_stream_host: a directed vector table plus randomized transactions
// checked every cycle against a transaction-level model of the host.
module tb_fc_stream_host;
   localparam int M  = 8;
   localparam int N  = 6;
   localparam int T  = 16;
   localparam int XW = $clog2(N);
   localparam int YW = $clog2(M);

   logic                clk = 1'b0;
   logic                reset;
   logic                start;
   logic                load_en;
   logic [XW-1:0]       load_addr;
   logic signed [T-1:0] load_data;
   logic                tx_valid;
   logic                tx_ready;
   logic signed [T-1:0] tx_data;
   logic                rx_valid;
   logic                rx_ready;
   logic signed [T-1:0] rx_data;
   logic [YW-1:0]       res_addr;
   logic signed [T-1:0] res_data;
   logic                busy;
   logic                done;
   logic [31:0]         cycle_count;

   always #5 clk = ~clk;

   fc_stream_host #(.M(M), .N(N), .T(T)) dut (
      .clk(clk), .reset(reset), .start(start), .load_en(load_en),
      .load_addr(load_addr), .load_data(load_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
      .res_addr(res_addr), .res_data(res_data),
      .busy(busy), .done(done), .cycle_count(cycle_count)
   );

   int checks   = 0;
   int failures = 0;

   // Model: phase 0 idle, 1 running, 2 finished; counts of beats so far in each direction.
   int                  m_phase;
   int                  txb;
   int                  rxb;
   int                  mcyc;
   logic signed [T-1:0] xm [N];
   logic signed [T-1:0] ym [M];

   typedef struct {
      logic st; logic tr; logic rv; int rd;
      logic etv; int etd; logic eb; logic ed; logic er; int ecc;
   } vec_t;
   vec_t tbl [17];
   int   xv [N];
   int   yv [M];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; txb = 0; rxb = 0; mcyc = 0;
      for (int i = 0; i < N; i++) xm[i] = '0;
      for (int i = 0; i < M; i++) ym[i] = '0;
   endtask

   // Called at a falling edge: check outputs, drive inputs, advance the model, wait a cycle.
   task automatic cyc(input logic st, input logic le, input int la, input int ld,
                      input logic tr, input logic rv, input int rd, input logic rs);
      logic                etv, erdy, both;
      logic signed [T-1:0] etd;
      etv  = (m_phase == 1) && (txb < N);
      etd  = etv ? xm[txb] : '0;
      erdy = (m_phase == 1) && (rxb < M);
      both = (txb == N) && (rxb == M);
      chk("busy",        32'(busy),     32'(m_phase == 1));
      chk("done",        32'(done),     32'(m_phase == 2));
      chk("tx_valid",    32'(tx_valid), 32'(etv));
      chk("tx_data",     32'(tx_data),  32'(etd));
      chk("rx_ready",    32'(rx_ready), 32'(erdy));
      chk("cycle_count", cycle_count,   32'(mcyc));
      start = st; load_en = le; load_addr = XW'(la); load_data = T'(ld);
      tx_ready = tr; rx_valid = rv; rx_data = T'(rd); reset = rs;
      if (rs) model_reset();
      else if (m_phase == 1) begin
         if (etv && tr) txb++;
         if (erdy && rv) begin ym[rxb] = T'(rd); rxb++; end
         mcyc++;
         if (both) m_phase = 2;
      end else begin
         if (le && la < N) xm[la] = T'(ld);
         if (st) begin m_phase = 1; txb = 0; rxb = 0; mcyc = 0; end
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      start = 0; load_en = 0; tx_ready = 0; rx_valid = 0; reset = 0;
   endtask

   task automatic check_res();
      idle_inputs();
      for (int i = 0; i < M; i++) begin
         res_addr = YW'(i);
         #1;
         chk("res_data", 32'(res_data), 32'(ym[i]));
      end
      @(negedge clk);
   endtask

   // mode 0: ready always 1; 1: ready pattern 1,0,0,1; 2: random. lat>0: rx words start after lat cycles.
   task automatic run_txn(input int mode, input int noise, input int lat);
      int   k, bc;
      logic r_tr, r_rv, r_st, r_le;
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      k = 0; bc = 0;
      while (m_phase != 2 && k < 1000) begin
         if (busy) bc++;
         case (mode)
            0:       r_tr = 1'b1;
            1:       r_tr = (k % 4 == 0) || (k % 4 == 3);
            default: r_tr = 1'($urandom_range(0, 1));
         endcase
         r_rv = (lat > 0) ? (k >= lat) : ($urandom_range(0, 2) == 0);
         r_st = (noise > 0) && ($urandom_range(0, 7) == 0);
         r_le = (noise > 1) || ((noise > 0) && ($urandom_range(0, 3) == 0));
         cyc(r_st, r_le, int'($urandom_range(0, 7)), int'($urandom), r_tr, r_rv, int'($urandom), 0);
         k++;
      end
      if (k >= 1000) chk("txn_timeout", 32'(k), 32'(0));
      chk("run_cycles", cycle_count, 32'(bc));
      cyc(0, 0, 0, 0, 0, 1, int'($urandom), 0);
      cyc(0, 0, 0, 0, 1, 1, int'($urandom), 0);
      check_res();
   endtask

   function automatic vec_t mk(input logic st, input logic tr, input logic rv, input int rd,
                               input logic etv, input int etd, input logic eb, input logic ed,
                               input logic er, input int ecc);
      vec_t v;
      v.st = st; v.tr = tr; v.rv = rv; v.rd = rd;
      v.etv = etv; v.etd = etd; v.eb = eb; v.ed = ed; v.er = er; v.ecc = ecc;
      return v;
   endfunction

   initial begin
      xv = '{3, -1, 7, 0, 5, -2};
      yv = '{12, -7, 300, -32768, 32767, 0, -1, 45};
      tbl[0] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < N; i++) tbl[1+i] = mk(0, 1, 0, 0, 1, xv[i], 1, 0, 1, i);
      for (int i = 0; i < M; i++) tbl[7+i] = mk(0, 1, 1, yv[i], 0, 0, 1, 0, 1, 6 + i);
      tbl[15] = mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 14);
      tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 15);

      reset = 1; start = 0; load_en = 0; load_addr = '0; load_data = '0;
      tx_ready = 0; rx_valid = 0; rx_data = '0; res_addr = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      model_reset();

      // Directed load (addresses 6 and 7 are out of range) and the table transaction.
      for (int i = 0; i < N; i++) cyc(0, 1, i, xv[i], 0, 0, 0, 0);
      cyc(0, 1, 6, 1234, 0, 0, 0, 0);
      cyc(0, 1, 7, -555, 0, 0, 0, 0);
      for (int k = 0; k < 17; k++) begin
         chk("tbl_tx_valid",    32'(tx_valid),    32'(tbl[k].etv));
         chk("tbl_tx_data",     32'(tx_data),     tbl[k].etd);
         chk("tbl_busy",        32'(busy),        32'(tbl[k].eb));
         chk("tbl_done",        32'(done),        32'(tbl[k].ed));
         chk("tbl_rx_ready",    32'(rx_ready),    32'(tbl[k].er));
         chk("tbl_cycle_count", cycle_count,      tbl[k].ecc);
         cyc(tbl[k].st, 0, 0, 0, tbl[k].tr, tbl[k].rv, tbl[k].rd, 0);
      end
      for (int i = 0; i < M; i++) begin
         res_addr = YW'(i);
         #1;
         chk("tbl_res_data", 32'(res_data), yv[i]);
      end
      @(negedge clk);
      repeat (3) cyc(0, 0, 0, 0, 1, 1, 99, 0);
      check_res();

      // Stall pattern, fixed latency, and randomized transactions with noise during RUN.
      run_txn(1, 0, 0);
      run_txn(0, 1, 4);
      run_txn(0, 2, 0);
      run_txn(0, 0, 0);
      for (int t = 0; t < 6; t++) begin
         for (int j = 0; j < 4; j++)
            cyc(0, 1, int'($urandom_range(0, 7)), int'($urandom), 0, 0, 0, 0);
         run_txn(t % 3, 1, 0);
      end

      // Reset mid-transaction after three beats, with start and load in the reset cycle.
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) cyc(0, 0, 0, 0, 1, 0, 0, 0);
      cyc(1, 1, 2, 77, 1, 1, 5, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      check_res();
      for (int i = 0; i < N; i++) cyc(0, 1, i, 40 - 9 * i, 0, 0, 0, 0);
      run_txn(0, 0, 0);
      run_txn(2, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
